operand_stage: RTL
==================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits and register count at 8.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, and SHALL expose the following ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- InValid  in  1  command valid
- InReady  out  1  stage can accept a command
- ReadNumA  in  3  source register for A
- ReadNumB  in  3  source register for B
- ShiftIn  in  2  shift applied to B
- AluOpIn  in  2  ALU opcode, passed through
- AselIn  in  1  1 forces Ain to zero
- BselIn  in  1  1 selects the immediate for Bin
- Imm5In  in  5  immediate operand
- WriteEn  in  1  register-file write strobe
- WriteNum  in  3  write register index
- WriteData  in  16  write data
- OutValid  out  1  operands valid toward the ALU
- OutReady  in  1  ALU consumes the operands
- Ain  out  16  A operand
- Bin  out  16  B operand
- AluOp  out  2  latched opcode

Function
REQ-003 The block SHALL contain R0..R7 (16 bits each); a write occurs at a rising edge when WriteEn=1, in any state.
REQ-004 The FSM states SHALL be IDLE, READ_A, READ_B and OUT.
REQ-005 InReady SHALL be 1 only in IDLE.
REQ-006 InValid&InReady at edge N SHALL latch all command fields and move the FSM to READ_A.
REQ-007 At edge N+1, A SHALL load R[ReadNumA latched] and the FSM SHALL move to READ_B.
REQ-008 At edge N+2, B SHALL load R[ReadNumB latched] and the FSM SHALL move to OUT.
REQ-009 OutValid SHALL equal (state==OUT); minimum command-to-OutValid latency is 3 edges.
REQ-010 In OUT, Ain, Bin and AluOp SHALL remain stable until OutValid&OutReady at an edge, which SHALL return the FSM to IDLE.
REQ-011 OutReady outside OUT SHALL be ignored; InValid outside IDLE SHALL be ignored (no queuing).
REQ-012 Ain SHALL be 16'h0000 when AselIn (latched)=1, otherwise A.
REQ-013 Bin SHALL be {11'b0, Imm5} when BselIn (latched)=1, otherwise shifted B.
REQ-014 The B shift SHALL be: 00 B; 01 B<<1 with LSB 0; 10 B>>1 with MSB 0; 11 B>>1 with MSB=B[15].
REQ-015 A write and a read of the same register at the same edge SHALL return the pre-write value, unless OPERAND_BYPASS_EN is defined.
REQ-016 Ain, Bin and AluOp SHALL be driven from registers and the shift/select logic only, with no combinational path from any input port.

Reset
REQ-017 While rst_n=0, independent of clk, the block SHALL hold R0..R7=0, A=B=0, latched command=0, state=IDLE, InReady=1, OutValid=0, Ain=Bin=0 and AluOp=00.
REQ-018 Reset asserted in any state mid-operation SHALL abort the command with no output handshake.
REQ-019 The first command SHALL be accepted at the first edge after rst_n rises with InValid=1.

Configuration
REQ-020 With OPERAND_BYPASS_EN defined, a same-edge WriteEn to the register being loaded into A or B SHALL load WriteData instead of the stored value.
REQ-021 Without OPERAND_BYPASS_EN, the stored (pre-write) value SHALL be loaded, and the register file SHALL still take WriteData at that edge.

Verification
REQ-022 Write R1=0x0005, R2=0x0003; command A=R1, B=R2, Shift=00, AluOp=00 -> OutValid high 3 edges after accept, Ain=0x0005, Bin=0x0003, AluOp=00.
REQ-023 R3=0x8004, Shift=11 on B -> Bin=0xC002; Shift=10 -> Bin=0x4002; Shift=01 -> Bin=0x0008.
REQ-024 AselIn=1, BselIn=1, Imm5=5'h1F -> Ain=0x0000, Bin=0x001F.
REQ-025 OutReady held 0 for 5 cycles in OUT -> outputs stable, InReady=0; OutReady=1 -> IDLE at the next edge, InReady=1.
REQ-026 R4=0x1111 with WriteEn WriteNum=4 WriteData=0x2222 at the B-load edge -> Bin=0x1111 without the macro, 0x2222 with it; R4=0x2222 afterwards in both builds.
REQ-027 rst_n pulsed low in READ_B -> OutValid=0, InReady=1, all registers 0 immediately; the next command proceeds normally.

Source files
------------

// File: rtl/operand_stage.sv
// operand_stage: 8 x 16-bit register file feeding an ALU operand stage.
// A command is accepted in IDLE, A and B are fetched on the next two edges,
// and the operands are held in OUT until the ALU consumes them.
// Optional build macro: OPERAND_BYPASS_EN. When defined, a write on the same
// edge as an operand fetch forwards WriteData into the operand register.
//
// state  | meaning
// IDLE   | waiting for a command, InReady=1
// READ_A | fetching A from R[ReadNumA latched]
// READ_B | fetching B from R[ReadNumB latched]
// OUT    | operands valid, waiting for OutReady
module operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [2:0]  ReadNumA,
  input  logic [2:0]  ReadNumB,
  input  logic [1:0]  ShiftIn,
  input  logic [1:0]  AluOpIn,
  input  logic        AselIn,
  input  logic        BselIn,
  input  logic [4:0]  Imm5In,
  input  logic        WriteEn,
  input  logic [2:0]  WriteNum,
  input  logic [15:0] WriteData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [15:0] Ain,
  output logic [15:0] Bin,
  output logic [1:0]  AluOp
);

  typedef enum logic [1:0] {IDLE, READ_A, READ_B, OUT} state_t;

  state_t      state_q, state_d;
  logic [15:0] rf_q [8];
  logic [15:0] rf_d [8];
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [2:0]  ra_q, ra_d;
  logic [2:0]  rb_q, rb_d;
  logic [1:0]  shift_q, shift_d;
  logic [1:0]  op_q, op_d;
  logic        asel_q, asel_d;
  logic        bsel_q, bsel_d;
  logic [4:0]  imm_q, imm_d;
  logic [15:0] rd_a, rd_b;
  logic [15:0] b_shifted;

  // Register-file read ports, with optional same-edge write forwarding.
  always_comb begin
    rd_a = rf_q[ra_q];
    rd_b = rf_q[rb_q];
`ifdef OPERAND_BYPASS_EN
    if (WriteEn && (WriteNum == ra_q)) rd_a = WriteData;
    if (WriteEn && (WriteNum == rb_q)) rd_b = WriteData;
`else
    // The register file updates at the same edge; the fetch sees the old value.
`endif
  end

  // Next-state logic for the FSM, command latch, operands and register file.
  always_comb begin
    state_d = state_q;
    rf_d    = rf_q;
    a_d     = a_q;
    b_d     = b_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    shift_d = shift_q;
    op_d    = op_q;
    asel_d  = asel_q;
    bsel_d  = bsel_q;
    imm_d   = imm_q;
    if (WriteEn) rf_d[WriteNum] = WriteData;
    case (state_q)
      IDLE: begin
        if (InValid) begin
          ra_d    = ReadNumA;
          rb_d    = ReadNumB;
          shift_d = ShiftIn;
          op_d    = AluOpIn;
          asel_d  = AselIn;
          bsel_d  = BselIn;
          imm_d   = Imm5In;
          state_d = READ_A;
        end
      end
      READ_A: begin
        a_d     = rd_a;
        state_d = READ_B;
      end
      READ_B: begin
        b_d     = rd_b;
        state_d = OUT;
      end
      OUT: begin
        if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      shift_q <= '0;
      op_q    <= '0;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      shift_q <= shift_d;
      op_q    <= op_d;
      asel_q  <= asel_d;
      bsel_q  <= bsel_d;
      imm_q   <= imm_d;
    end
  end

  // Operand shaping from registered state only.
  always_comb begin
    case (shift_q)
      2'b00:   b_shifted = b_q;
      2'b01:   b_shifted = {b_q[14:0], 1'b0};
      2'b10:   b_shifted = {1'b0, b_q[15:1]};
      default: b_shifted = {b_q[15], b_q[15:1]};
    endcase
    Ain      = asel_q ? 16'h0000 : a_q;
    Bin      = bsel_q ? {11'b0, imm_q} : b_shifted;
    AluOp    = op_q;
    InReady  = (state_q == IDLE);
    OutValid = (state_q == OUT);
  end

endmodule
